fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Each cycle it addresses instruction memory with the PC count and captures the synchronous-read response one cycle later. Responses are queued with their PC tag and handed to decode through a valid/ready handshake.
- The PC has no stall input, so backpressure is handled by replay. When the queue cannot accept a response, the block drives the PC's branch port back to the dropped address. It also forwards execute-stage branches to the PC and flushes wrong-path fetches.

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with replay-based backpressure
module fetch_queue #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_cnt,
    output logic               pc_branch_valid,
    output logic [ADDR_W-1:0]  pc_branch_address,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               ex_branch_valid,
    input  logic [ADDR_W-1:0]  ex_branch_address,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic               req_valid;
    logic [ADDR_W-1:0]  req_pc;
    logic               squash;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic empty;
    logic full;
    logic rsp_live;
    logic pop;
    logic push;
    logic replay;

    assign imem_addr = pc_cnt;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign rsp_live = req_valid & ~squash;
    assign pop      = ~empty & id_ready;

    // An execute branch overrides both push and replay; the response is wrong-path.
    assign push   = ~ex_branch_valid & rsp_live & (~full | pop);
    assign replay = ~ex_branch_valid & rsp_live & full & ~pop;

    assign pc_branch_valid   = ~reset & (ex_branch_valid | replay);
    assign pc_branch_address = ex_branch_valid ? ex_branch_address : req_pc;

    assign id_valid = ~empty;
    assign id_instr = empty ? '0 : instr_mem[rd_ptr];
    assign id_pc    = empty ? '0 : pc_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_valid <= 1'b0;
            req_pc    <= '0;
            squash    <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            req_valid <= 1'b1;
            req_pc    <= pc_cnt;
            // Replay needs a live (unsquashed) response, so squash never lasts two cycles.
            squash    <= ex_branch_valid | replay;
            if (ex_branch_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue
module tb_fetch_queue;

    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  pc_cnt = '0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               ex_branch_valid = 1'b0;
    logic [ADDR_W-1:0]  ex_branch_address = '0;
    logic               id_ready = 1'b0;
    logic               pc_branch_valid;
    logic [ADDR_W-1:0]  pc_branch_address;
    logic [ADDR_W-1:0]  imem_addr;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [ADDR_W-1:0]  id_pc;

    fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_cnt            (pc_cnt),
        .pc_branch_valid   (pc_branch_valid),
        .pc_branch_address (pc_branch_address),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .ex_branch_valid   (ex_branch_valid),
        .ex_branch_address (ex_branch_address),
        .id_ready          (id_ready),
        .id_valid          (id_valid),
        .id_instr          (id_instr),
        .id_pc             (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t            q[$];
    bit                m_req_valid = 1'b0;
    logic [ADDR_W-1:0] m_req_pc = '0;
    bit                m_squash = 1'b0;
    bit                exp_br = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [INSTR_W-1:0] mem_f(logic [ADDR_W-1:0] a);
        return {5'h15, a, 5'h0A, a};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of fetched entries plus the in-flight request.
    always @(negedge clk) begin : cmp
        bit     live;
        bit     pop;
        entry_t head;
        if (reset) begin
            check("rst_id_valid", id_valid, 0);
            check("rst_pc_branch_valid", pc_branch_valid, 0);
            q.delete();
            m_req_valid = 1'b0;
            m_req_pc    = '0;
            m_squash    = 1'b0;
            exp_br      = 1'b0;
            exp_addr    = '0;
        end else begin
            head = (q.size() != 0) ? q[0] : '0;
            check("id_valid", id_valid, (q.size() != 0));
            check("id_pc", id_pc, head.pc);
            check("id_instr", id_instr, head.instr);
            check("imem_addr", imem_addr, pc_cnt);
            live = m_req_valid && !m_squash;
            pop  = (q.size() != 0) && id_ready;
            if (ex_branch_valid) begin
                exp_br   = 1'b1;
                exp_addr = ex_branch_address;
                q.delete();
                m_squash = 1'b1;
            end else if (live && q.size() == DEPTH && !pop) begin
                exp_br   = 1'b1;
                exp_addr = m_req_pc;
                m_squash = 1'b1;
            end else begin
                exp_br   = 1'b0;
                m_squash = 1'b0;
                if (pop) void'(q.pop_front());
                if (live) q.push_back({m_req_pc, imem_rdata});
            end
            check("pc_branch_valid", pc_branch_valid, exp_br);
            if (exp_br) check("pc_branch_address", pc_branch_address, exp_addr);
            m_req_valid = 1'b1;
            m_req_pc    = pc_cnt;
        end
    end

    // Environment: PC follows the expected jump requests, memory answers one cycle late.
    task automatic cycle();
        logic [ADDR_W-1:0] prev;
        @(posedge clk);
        #1;
        prev       = pc_cnt;
        imem_rdata = mem_f(prev);
        if (!reset) pc_cnt = exp_br ? exp_addr : prev + 1'b1;
        #1;
    endtask

    task automatic restart(logic [ADDR_W-1:0] start, logic rdy);
        reset           = 1'b1;
        ex_branch_valid = 1'b0;
        id_ready        = rdy;
        pc_cnt          = start;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        // Streaming
        restart(11'd0, 1'b1);
        cycle();
        check("stream_lat1_valid", id_valid, 0);
        cycle();
        check("stream_lat2_valid", id_valid, 1);
        check("stream_first_pc", id_pc, 0);
        check("stream_first_instr", id_instr, 32'hA800_5000);
        check("stream_no_branch", pc_branch_valid, 0);
        repeat (6) cycle();
        check("stream_pc6", id_pc, 6);

        // Fill and replay
        restart(11'd0, 1'b0);
        repeat (5) cycle();
        check("fill_replay_valid", pc_branch_valid, 1);
        check("fill_replay_addr", pc_branch_address, 4);
        cycle();
        check("fill_squash_no_branch", pc_branch_valid, 0);
        check("fill_head0", id_pc, 0);
        cycle();
        check("fill_replay2_valid", pc_branch_valid, 1);
        check("fill_replay2_addr", pc_branch_address, 4);
        cycle();
        id_ready = 1'b1;
        check("fill_drain_head0", id_pc, 0);
        repeat (3) cycle();
        check("fill_drain_head3", id_pc, 3);
        repeat (4) cycle();

        // Execute branch with three queued entries
        restart(11'd0, 1'b0);
        repeat (4) cycle();
        ex_branch_valid   = 1'b1;
        ex_branch_address = 11'h2A0;
        #1;
        check("exbr_valid", pc_branch_valid, 1);
        check("exbr_addr", pc_branch_address, 11'h2A0);
        cycle();
        ex_branch_valid = 1'b0;
        id_ready        = 1'b1;
        check("exbr_flushed", id_valid, 0);
        cycle();
        check("exbr_squashed", id_valid, 0);
        cycle();
        check("exbr_first_valid", id_valid, 1);
        check("exbr_first_pc", id_pc, 11'h2A0);
        repeat (3) cycle();

        // Simultaneous push/pop at full, then branch during replay
        restart(11'd0, 1'b0);
        repeat (5) cycle();
        id_ready = 1'b1;
        #1;
        check("full_pushpop_no_replay", pc_branch_valid, 0);
        cycle();
        check("full_pushpop_head1", id_pc, 1);
        id_ready = 1'b0;
        #1;
        check("full_still_full_replay", pc_branch_valid, 1);
        check("full_still_full_addr", pc_branch_address, 5);
        cycle();
        cycle();
        ex_branch_valid   = 1'b1;
        ex_branch_address = 11'h155;
        #1;
        check("brrep_valid", pc_branch_valid, 1);
        check("brrep_addr", pc_branch_address, 11'h155);
        cycle();
        ex_branch_valid = 1'b0;
        check("brrep_flushed", id_valid, 0);
        repeat (4) cycle();

        // Asynchronous reset mid-stream
        restart(11'd0, 1'b1);
        repeat (5) cycle();
        check("midrst_pre_valid", id_valid, 1);
        ex_branch_valid   = 1'b1;
        ex_branch_address = 11'h03F;
        #1;
        reset = 1'b1;
        #1;
        check("midrst_id_valid", id_valid, 0);
        check("midrst_pc_branch_valid", pc_branch_valid, 0);
        ex_branch_valid = 1'b0;
        pc_cnt          = 11'h100;
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
        check("midrst_resume_valid", id_valid, 1);
        check("midrst_resume_pc", id_pc, 11'h100);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
